// File: rtl/wreg_pkg.sv
// Shared definitions for the destination-register selector and pending-write scoreboard.
package wreg_pkg;

    typedef enum logic [1:0] {
        WSEL_RT = 2'b00,
        WSEL_SP = 2'b01,
        WSEL_RA = 2'b10,
        WSEL_RD = 2'b11
    } wsel_e;

    localparam int DEF_SP_IDX = 29;
    localparam int DEF_RA_IDX = 31;

endpackage

// File: rtl/wreg_scoreboard_if.sv
// Issue/writeback bundle between the control unit (master) and the write-register scoreboard (slave).
interface wreg_scoreboard_if #(
    parameter int REG_W    = 5,
    parameter int NUM_REGS = 32
);
    logic [1:0]          selector;
    logic [REG_W-1:0]    rt_idx;
    logic [REG_W-1:0]    rd_idx;
    logic [REG_W-1:0]    src_a_idx;
    logic [REG_W-1:0]    src_b_idx;
    logic                src_a_used;
    logic                src_b_used;
    logic                issue_valid;
    logic                issue_ready;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_idx;
    logic                flush;
    logic [REG_W-1:0]    dest_comb;
    logic [REG_W-1:0]    dest_q;
    logic [NUM_REGS-1:0] busy_vec;
    logic [REG_W:0]      pend_count;
    logic                wb_err;

    modport master (
        output selector, rt_idx, rd_idx, src_a_idx, src_b_idx, src_a_used, src_b_used,
               issue_valid, wb_valid, wb_idx, flush,
        input  issue_ready, dest_comb, dest_q, busy_vec, pend_count, wb_err
    );

    modport slave (
        input  selector, rt_idx, rd_idx, src_a_idx, src_b_idx, src_a_used, src_b_used,
               issue_valid, wb_valid, wb_idx, flush,
        output issue_ready, dest_comb, dest_q, busy_vec, pend_count, wb_err
    );
endinterface

// File: rtl/wreg_dest_sel.sv
// 4:1 destination-register mux: rt, stack pointer, return address or rd.
module wreg_dest_sel
    import wreg_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int SP_IDX = DEF_SP_IDX,
    parameter int RA_IDX = DEF_RA_IDX
) (
    input  logic [1:0]       selector,
    input  logic [REG_W-1:0] rt_idx,
    input  logic [REG_W-1:0] rd_idx,
    output logic [REG_W-1:0] dest
);

    // Selector decode into the destination index
    always_comb begin
        dest = rt_idx;
        case (wsel_e'(selector))
            WSEL_RT: dest = rt_idx;
            WSEL_SP: dest = REG_W'(SP_IDX);
            WSEL_RA: dest = REG_W'(RA_IDX);
            WSEL_RD: dest = rd_idx;
            default: dest = rt_idx;
        endcase
    end

endmodule

// File: rtl/wreg_scoreboard.sv
// Destination selection plus pending-write scoreboard; stalls issue on RAW/WAW hazards,
// with a same-cycle writeback bypass.
module wreg_scoreboard
    import wreg_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_REGS = 32,
    parameter int SP_IDX   = DEF_SP_IDX,
    parameter int RA_IDX   = DEF_RA_IDX
) (
    input  logic           clk,
    input  logic           reset_n,
    wreg_scoreboard_if.slave bus
);

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [REG_W:0]      CNT_ONE  = {{REG_W{1'b0}}, 1'b1};

    logic [REG_W-1:0]    dest_s;
    logic [NUM_REGS-1:0] wb_hit_s;
    logic [NUM_REGS-1:0] dest_hot_s;
    logic [NUM_REGS-1:0] busy_eff_s;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [REG_W:0]      pend_next_s;
    logic                ready_s;
    logic                accept_s;
    logic                set_s;
    logic                clr_s;
    logic                wb_bad_s;

    logic [NUM_REGS-1:0] busy_vec_r;
    logic [REG_W:0]      pend_count_r;
    logic [REG_W-1:0]    dest_q_r;
    logic                wb_err_r;

    wreg_dest_sel #(
        .REG_W  (REG_W),
        .SP_IDX (SP_IDX),
        .RA_IDX (RA_IDX)
    ) u_dest_sel (
        .selector (bus.selector),
        .rt_idx   (bus.rt_idx),
        .rd_idx   (bus.rd_idx),
        .dest     (dest_s)
    );

    // Hazard detection with the writeback bypass, and the next scoreboard state
    always_comb begin
        wb_hit_s    = bus.wb_valid ? (ONE_HOT0 << bus.wb_idx) : {NUM_REGS{1'b0}};
        dest_hot_s  = ONE_HOT0 << dest_s;
        busy_eff_s  = busy_vec_r & ~wb_hit_s;
        ready_s     = !(bus.src_a_used && busy_eff_s[bus.src_a_idx])
                   && !(bus.src_b_used && busy_eff_s[bus.src_b_idx])
                   && !busy_eff_s[dest_s]
                   && !bus.flush;
        accept_s    = bus.issue_valid && ready_s;
        // r0 is hard-wired zero, so it is never tracked as pending
        set_s       = accept_s && (dest_s != {REG_W{1'b0}});
        clr_s       = bus.wb_valid && busy_vec_r[bus.wb_idx];
        wb_bad_s    = bus.wb_valid && !busy_vec_r[bus.wb_idx];
        // Clear first, then set, so a same-register set wins
        busy_next_s = (busy_vec_r & ~(clr_s ? wb_hit_s : {NUM_REGS{1'b0}}))
                    | (set_s ? dest_hot_s : {NUM_REGS{1'b0}});
        case ({set_s, clr_s})
            2'b10:   pend_next_s = pend_count_r + CNT_ONE;
            2'b01:   pend_next_s = pend_count_r - CNT_ONE;
            default: pend_next_s = pend_count_r;
        endcase
    end

    // Scoreboard state; flush empties the board but keeps dest_q and the error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec_r   <= {NUM_REGS{1'b0}};
            pend_count_r <= {(REG_W+1){1'b0}};
            dest_q_r     <= {REG_W{1'b0}};
            wb_err_r     <= 1'b0;
        end else if (bus.flush) begin
            busy_vec_r   <= {NUM_REGS{1'b0}};
            pend_count_r <= {(REG_W+1){1'b0}};
        end else begin
            busy_vec_r   <= busy_next_s;
            pend_count_r <= pend_next_s;
            if (accept_s) begin
                dest_q_r <= dest_s;
            end
            if (wb_bad_s) begin
                wb_err_r <= 1'b1;
            end
        end
    end

    assign bus.dest_comb   = dest_s;
    assign bus.issue_ready = ready_s;
    assign bus.busy_vec    = busy_vec_r;
    assign bus.pend_count  = pend_count_r;
    assign bus.dest_q      = dest_q_r;
    assign bus.wb_err      = wb_err_r;

endmodule

// File: tb/tb_wreg_scoreboard.sv
// Randomized and directed bench for wreg_scoreboard against a set-based pending-write model.
module tb_wreg_scoreboard;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wreg_scoreboard_if #(.REG_W(5), .NUM_REGS(32)) bus();

    wreg_scoreboard #(.REG_W(5), .NUM_REGS(32), .SP_IDX(29), .RA_IDX(31)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: the set of registers with a write in flight
    bit         pend_m[int];
    logic [4:0] dest_q_m = 5'd0;
    bit         err_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] sel_m(input logic [1:0] s, input logic [4:0] rt, input logic [4:0] rd);
        case (s)
            2'd0:    return rt;
            2'd1:    return 5'd29;
            2'd2:    return 5'd31;
            default: return rd;
        endcase
    endfunction

    function automatic bit busy_eff_m(input int r);
        return pend_m.exists(r) && !(bus.wb_valid && int'(bus.wb_idx) == r);
    endfunction

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        logic [31:0] vec;
        logic [4:0]  d;
        bit          rdy;
        if (!reset_n) begin
            pend_m.delete();
            dest_q_m = 5'd0;
            err_m    = 1'b0;
        end
        vec = 32'd0;
        foreach (pend_m[k]) vec[k] = 1'b1;
        chk("busy_vec", bus.busy_vec, vec);
        chk("pend_count", bus.pend_count, pend_m.num());
        chk("dest_q", bus.dest_q, dest_q_m);
        chk("wb_err", bus.wb_err, err_m);
        if (reset_n) begin
            d   = sel_m(bus.selector, bus.rt_idx, bus.rd_idx);
            rdy = !(bus.src_a_used && busy_eff_m(bus.src_a_idx))
               && !(bus.src_b_used && busy_eff_m(bus.src_b_idx))
               && !busy_eff_m(d) && !bus.flush;
            chk("dest_comb", bus.dest_comb, d);
            chk("issue_ready", bus.issue_ready, rdy);
            if (bus.flush) begin
                pend_m.delete();
            end else begin
                if (bus.wb_valid) begin
                    if (pend_m.exists(int'(bus.wb_idx))) pend_m.delete(int'(bus.wb_idx));
                    else err_m = 1'b1;
                end
                if (bus.issue_valid && rdy) begin
                    dest_q_m = d;
                    if (d != 5'd0) pend_m[int'(d)] = 1'b1;
                end
            end
        end
    end

    task automatic idle();
        bus.selector    = 2'd0;
        bus.rt_idx      = 5'd0;
        bus.rd_idx      = 5'd0;
        bus.src_a_idx   = 5'd0;
        bus.src_b_idx   = 5'd0;
        bus.src_a_used  = 1'b0;
        bus.src_b_used  = 1'b0;
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_idx      = 5'd0;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Small index pool so hazards are frequent
    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 5'(r);
        return (r == 8) ? 5'd29 : 5'd31;
    endfunction

    task automatic rand_drive(input bit legal_wb_only);
        int keys[$];
        bus.selector    = 2'($urandom_range(0, 3));
        bus.rt_idx      = pick();
        bus.rd_idx      = pick();
        bus.src_a_idx   = pick();
        bus.src_b_idx   = pick();
        bus.src_a_used  = 1'($urandom_range(0, 1));
        bus.src_b_used  = 1'($urandom_range(0, 1));
        bus.issue_valid = ($urandom_range(0, 3) != 0);
        bus.flush       = ($urandom_range(0, 24) == 0);
        foreach (pend_m[k]) keys.push_back(k);
        if (legal_wb_only) begin
            bus.wb_valid = (keys.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.wb_idx   = (keys.size() > 0) ? 5'(keys[$urandom_range(0, keys.size() - 1)]) : 5'd0;
        end else begin
            bus.wb_valid = ($urandom_range(0, 2) == 0);
            bus.wb_idx   = pick();
        end
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step();
            rand_drive(i < 300);
        end

        // Directed scenarios from a clean reset
        step();
        idle();
        reset_n = 1'b0;
        #2;
        chk("rst_busy", bus.busy_vec, 32'd0);
        chk("rst_pend", bus.pend_count, 6'd0);
        chk("rst_destq", bus.dest_q, 5'd0);
        chk("rst_err", bus.wb_err, 1'b0);
        step();
        reset_n = 1'b1;

        step(); bus.selector = 2'd3; bus.rd_idx = 5'd8; bus.issue_valid = 1'b1;
        #2; chk("t1_ready", bus.issue_ready, 1'b1); chk("t1_dest", bus.dest_comb, 5'd8);
        step(); idle();
        #2; chk("t1_destq", bus.dest_q, 5'd8); chk("t1_busy", bus.busy_vec, 32'h0000_0100);
        chk("t1_pend", bus.pend_count, 6'd1);

        step(); bus.selector = 2'd3; bus.rd_idx = 5'd9; bus.src_a_idx = 5'd8;
        bus.src_a_used = 1'b1; bus.issue_valid = 1'b1;
        #2; chk("t2_raw_stall", bus.issue_ready, 1'b0);
        bus.issue_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_idx = 5'd8;
        #1; chk("t2_bypass", bus.issue_ready, 1'b1);
        step(); idle();
        #2; chk("t2_busy", bus.busy_vec, 32'd0); chk("t2_pend", bus.pend_count, 6'd0);

        step(); bus.selector = 2'd1; bus.issue_valid = 1'b1;
        #2; chk("t3_sp", bus.dest_comb, 5'd29);
        step(); bus.selector = 2'd2;
        #2; chk("t3_ra", bus.dest_comb, 5'd31); chk("t3_ready", bus.issue_ready, 1'b1);
        step();
        #2; chk("t3_busy", bus.busy_vec, 32'hA000_0000); chk("t3_pend", bus.pend_count, 6'd2);
        chk("t3_waw", bus.issue_ready, 1'b0);

        step(); idle(); bus.issue_valid = 1'b1;
        #2; chk("t4_ready", bus.issue_ready, 1'b1);
        step(); idle();
        #2; chk("t4_destq", bus.dest_q, 5'd0); chk("t4_busy", bus.busy_vec, 32'hA000_0000);
        chk("t4_pend", bus.pend_count, 6'd2);

        step(); bus.selector = 2'd3; bus.rd_idx = 5'd5; bus.issue_valid = 1'b1;
        step(); bus.wb_valid = 1'b1; bus.wb_idx = 5'd5;
        #2; chk("t5_ready", bus.issue_ready, 1'b1);
        step(); idle();
        #2; chk("t5_busy", bus.busy_vec, 32'hA000_0020); chk("t5_pend", bus.pend_count, 6'd3);
        chk("t5_destq", bus.dest_q, 5'd5);
        bus.wb_valid = 1'b1; bus.wb_idx = 5'd7;
        step(); idle();
        #2; chk("t5_err", bus.wb_err, 1'b1); chk("t5_pend_kept", bus.pend_count, 6'd3);
        step();
        #2; chk("t5_err_sticky", bus.wb_err, 1'b1);

        step(); bus.flush = 1'b1; bus.selector = 2'd3; bus.rd_idx = 5'd6; bus.issue_valid = 1'b1;
        #2; chk("t6_flush_ready", bus.issue_ready, 1'b0);
        step(); idle();
        #2; chk("t6_busy", bus.busy_vec, 32'd0); chk("t6_pend", bus.pend_count, 6'd0);
        chk("t6_err", bus.wb_err, 1'b1); chk("t6_destq", bus.dest_q, 5'd5);

        step(); bus.selector = 2'd3; bus.rd_idx = 5'd4; bus.issue_valid = 1'b1;
        step(); idle();
        #2; chk("t7_busy", bus.busy_vec, 32'h0000_0010);
        reset_n = 1'b0;
        #1;
        chk("t7_async_busy", bus.busy_vec, 32'd0);
        chk("t7_async_pend", bus.pend_count, 6'd0);
        chk("t7_async_destq", bus.dest_q, 5'd0);
        chk("t7_async_err", bus.wb_err, 1'b0);
        step();
        reset_n = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
